ram_fifo_ctrl: RTL and testbench

Single-clock FIFO controller that turns an `altsyncram` instance in SIMPLE_DUAL_PORT mode into a synchronous FIFO. Port A is the write port and port B the read port. The block owns the write/read pointers, occupancy count and status flags. It drives the RAM's port-A write and port-B read controls and returns RAM data to the consumer. It sits between a streaming producer and the RAM macro in the elaborated netlist. The RAM is wired with one-cycle read latency: `ram_q_b` is valid the cycle after `ram_rden_b` is sampled.

---
 rtl/ram_fifo_pkg.sv | 15 +
 rtl/ram_fifo_prefetch.sv | 74 +++++++
 rtl/ram_fifo_ctrl.sv | 116 +++++++++++
 tb/tb_ram_fifo_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_fifo_pkg.sv
// Shared types and helpers for the RAM-backed FIFO controller and its
// showahead prefetch stage.
package ram_fifo_pkg;

  typedef enum logic [1:0] {
    PF_IDLE  = 2'd0,
    PF_FETCH = 2'd1,
    PF_VALID = 2'd2
  } pf_state_e;

  function automatic int ram_fifo_depth(input int widthad);
    return 1 << widthad;
  endfunction

endpackage

// File: rtl/ram_fifo_prefetch.sv
// Showahead output stage: keeps the registered head word plus one skid entry
// topped up from the RAM so the head is visible before it is popped.
module ram_fifo_prefetch
  import ram_fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic             ram_avail,
  input  logic             rdreq,
  input  logic [WIDTH-1:0] ram_q_b,
  output logic             fetch,
  output logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] q
);

  pf_state_e        state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d, skid_q, skid_d;
  logic             skid_v_q, skid_v_d, inflight_q, inflight_d;
  logic             head_v, h_v;
  logic [1:0]       occ;

  always_comb begin
    head_v     = (state_q == PF_VALID);
    pop        = rdreq & head_v & !sclr;
    // Slots already claimed once this cycle's pop is taken, in-flight read included.
    occ        = 2'(head_v) + 2'(skid_v_q) + 2'(inflight_q) - 2'(pop);
    fetch      = ram_avail & (occ < 2'd2) & !sclr;
    q_d        = q_q;
    skid_d     = skid_q;
    skid_v_d   = skid_v_q;
    inflight_d = fetch;
    h_v        = head_v;
    if (pop) begin
      h_v      = skid_v_q;
      q_d      = skid_q;
      skid_v_d = 1'b0;
    end
    if (inflight_q) begin
      if (h_v) begin
        skid_d   = ram_q_b;
        skid_v_d = 1'b1;
      end else begin
        q_d = ram_q_b;
        h_v = 1'b1;
      end
    end
    if (h_v)        state_d = PF_VALID;
    else if (fetch) state_d = PF_FETCH;
    else            state_d = PF_IDLE;
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      state_q    <= PF_IDLE;
      q_q        <= '0;
      skid_q     <= '0;
      skid_v_q   <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      q_q        <= q_d;
      skid_q     <= skid_d;
      skid_v_q   <= skid_v_d;
      inflight_q <= inflight_d;
    end
  end

  assign empty = (state_q != PF_VALID);
  assign q     = q_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Single-clock FIFO controller over a simple-dual-port RAM (A writes, B reads).
// Define RAM_FIFO_SHOWAHEAD_EN for first-word-fall-through output.
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int WIDTH             = 8,
  parameter int WIDTHAD           = 4,
  parameter int ALMOST_FULL_VALUE = 12
) (
  input  logic               clock0,
  input  logic               sclr,
  input  logic               wrreq,
  input  logic [WIDTH-1:0]   data,
  input  logic               rdreq,
  output logic [WIDTH-1:0]   q,
  output logic               empty,
  output logic               full,
  output logic               almost_full,
  output logic [WIDTHAD:0]   usedw,
  output logic               ram_wren_a,
  output logic [WIDTHAD-1:0] ram_address_a,
  output logic [WIDTH-1:0]   ram_data_a,
  output logic               ram_rden_b,
  output logic [WIDTHAD-1:0] ram_address_b,
  input  logic [WIDTH-1:0]   ram_q_b
);

  localparam int               DEPTH   = ram_fifo_depth(WIDTHAD);
  localparam logic [WIDTHAD:0] DEPTH_W = (WIDTHAD+1)'(DEPTH);
  localparam logic [WIDTHAD:0] AF_W    = (WIDTHAD+1)'(ALMOST_FULL_VALUE);
  localparam logic [WIDTHAD:0] ONE_W   = (WIDTHAD+1)'(1);

  logic [WIDTHAD-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTHAD:0]   usedw_q, usedw_d;
  logic               full_q, full_d, af_q, af_d;
  logic               wr_acc, rd_acc, pop;

  assign wr_acc = wrreq & !full_q & !sclr;

`ifdef RAM_FIFO_SHOWAHEAD_EN
  // RAM-resident words not yet fetched; usedw also counts the output buffer.
  logic [WIDTHAD:0] ram_cnt_q, ram_cnt_d;

  ram_fifo_prefetch #(.WIDTH(WIDTH)) u_prefetch (
    .clk       (clock0),
    .sclr      (sclr),
    .ram_avail (ram_cnt_q != '0),
    .rdreq     (rdreq),
    .ram_q_b   (ram_q_b),
    .fetch     (rd_acc),
    .pop       (pop),
    .empty     (empty),
    .q         (q)
  );

  always_comb begin
    ram_cnt_d = ram_cnt_q;
    if (wr_acc && !rd_acc)      ram_cnt_d = ram_cnt_q + ONE_W;
    else if (!wr_acc && rd_acc) ram_cnt_d = ram_cnt_q - ONE_W;
  end

  always_ff @(posedge clock0) begin
    if (sclr) ram_cnt_q <= '0;
    else      ram_cnt_q <= ram_cnt_d;
  end
`else
  logic empty_q, empty_d;

  assign rd_acc  = rdreq & !empty_q & !sclr;
  assign pop     = rd_acc;
  assign empty   = empty_q;
  assign q       = ram_q_b;
  assign empty_d = (usedw_d == '0);

  always_ff @(posedge clock0) begin
    if (sclr) empty_q <= 1'b1;
    else      empty_q <= empty_d;
  end
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q + WIDTHAD'(wr_acc);
    rd_ptr_d = rd_ptr_q + WIDTHAD'(rd_acc);
    usedw_d  = usedw_q;
    if (wr_acc && !pop)      usedw_d = usedw_q + ONE_W;
    else if (!wr_acc && pop) usedw_d = usedw_q - ONE_W;
    full_d = (usedw_d == DEPTH_W);
    af_d   = (usedw_d >= AF_W);
  end

  always_ff @(posedge clock0) begin
    if (sclr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usedw_q  <= usedw_d;
      full_q   <= full_d;
      af_q     <= af_d;
    end
  end

  assign ram_wren_a    = wr_acc;
  assign ram_address_a = wr_ptr_q;
  assign ram_data_a    = data;
  assign ram_rden_b    = rd_acc;
  assign ram_address_b = rd_ptr_q;
  assign usedw         = usedw_q;
  assign full          = full_q;
  assign almost_full   = af_q;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: vector table, directed corner sequences and random
// traffic against a queue-based FIFO model; RAM modelled behaviourally here.
module tb_ram_fifo_ctrl;

  localparam int DEPTH = 16;
  localparam int AFV   = 12;

  logic       clk = 1'b0;
  logic       sclr, wrreq, rdreq;
  logic [7:0] data, q, ram_data_a, ram_q_b;
  logic       empty, full, almost_full, ram_wren_a, ram_rden_b;
  logic [4:0] usedw;
  logic [3:0] ram_address_a, ram_address_b;

  ram_fifo_ctrl #(.WIDTH(8), .WIDTHAD(4), .ALMOST_FULL_VALUE(AFV)) dut (
    .clock0        (clk),
    .sclr          (sclr),
    .wrreq         (wrreq),
    .data          (data),
    .rdreq         (rdreq),
    .q             (q),
    .empty         (empty),
    .full          (full),
    .almost_full   (almost_full),
    .usedw         (usedw),
    .ram_wren_a    (ram_wren_a),
    .ram_address_a (ram_address_a),
    .ram_data_a    (ram_data_a),
    .ram_rden_b    (ram_rden_b),
    .ram_address_b (ram_address_b),
    .ram_q_b       (ram_q_b)
  );

  // clock / RAM macro model with one-cycle read latency
  always #5 clk = ~clk;

  logic [7:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_wren_a) mem[ram_address_a] <= ram_data_a;
    if (ram_rden_b) ram_q_b <= mem[ram_address_b];
  end

  // scoreboard
  logic [7:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         wr_cnt = 0;
  int         rd_cnt = 0;
  logic [7:0] pend;
  logic       pend_v = 1'b0;
  logic       smp_wren;
  logic [3:0] smp_waddr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // One clock: drive, check combinational RAM controls, advance model, check state.
  task automatic cycle(input logic w, input logic [7:0] d, input logic r, input logic s);
    logic wr_ok, rd_ok;
    wrreq = w; data = d; rdreq = r; sclr = s;
    @(negedge clk);
    smp_wren  = ram_wren_a;
    smp_waddr = ram_address_a;
    wr_ok = w && !s && (exp_q.size() < DEPTH);
`ifdef RAM_FIFO_SHOWAHEAD_EN
    rd_ok = r && !s && (empty === 1'b0);
    if (empty === 1'b0) begin
      check("sa_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("sa_head", q, exp_q[0]);
    end
`else
    rd_ok = r && !s && (exp_q.size() != 0);
    check("rden", ram_rden_b, rd_ok);
    if (rd_ok) check("raddr", ram_address_b, rd_cnt % DEPTH);
`endif
    check("wren", ram_wren_a, wr_ok);
    if (wr_ok) begin
      check("waddr", ram_address_a, wr_cnt % DEPTH);
      check("wdata", ram_data_a, d);
    end
    if (ram_wren_a && ram_rden_b) check("addr_clash", ram_address_a != ram_address_b, 1);
    @(posedge clk);
    if (s) begin
      exp_q.delete();
      wr_cnt = 0; rd_cnt = 0; pend_v = 1'b0;
    end else begin
      pend_v = 1'b0;
      if (rd_ok && exp_q.size() != 0) begin
        pend = exp_q.pop_front(); pend_v = 1'b1; rd_cnt++;
      end
      if (wr_ok) begin
        exp_q.push_back(d); wr_cnt++;
      end
    end
    #1;
    check("usedw", usedw, exp_q.size());
    check("full", full, exp_q.size() == DEPTH);
    check("almost_full", almost_full, exp_q.size() >= AFV);
`ifdef RAM_FIFO_SHOWAHEAD_EN
    if (exp_q.size() == 0) check("sa_empty", empty, 1);
`else
    check("empty", empty, exp_q.size() == 0);
    if (pend_v) check("rd_data", q, pend);
`endif
  endtask

  typedef struct {
    logic       w;
    logic [7:0] d;
    logic       r;
    logic       exp_wren;
    logic [3:0] exp_waddr;
    logic [4:0] exp_usedw;
    logic       exp_empty;
  } vec_t;

  vec_t vecs[8];

  initial begin
    sclr = 1'b1; wrreq = 1'b0; rdreq = 1'b0; data = '0;
    cycle(0, 8'h00, 0, 1);
    cycle(1, 8'hEE, 1, 1);
    check("rst_usedw", usedw, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_af", almost_full, 0);
    check("rst_wren", smp_wren, 0);

`ifndef RAM_FIFO_SHOWAHEAD_EN
    vecs[0] = '{1, 8'h11, 0, 1, 4'd0, 5'd1, 0};
    vecs[1] = '{1, 8'h22, 0, 1, 4'd1, 5'd2, 0};
    vecs[2] = '{1, 8'h33, 0, 1, 4'd2, 5'd3, 0};
    vecs[3] = '{0, 8'h00, 1, 0, 4'd3, 5'd2, 0};
    vecs[4] = '{0, 8'h00, 1, 0, 4'd3, 5'd1, 0};
    vecs[5] = '{1, 8'h44, 1, 1, 4'd3, 5'd1, 0};
    vecs[6] = '{0, 8'h00, 1, 0, 4'd4, 5'd0, 1};
    vecs[7] = '{0, 8'h00, 1, 0, 4'd4, 5'd0, 1};
    for (int i = 0; i < 8; i++) begin
      cycle(vecs[i].w, vecs[i].d, vecs[i].r, 0);
      check("tbl_wren", smp_wren, vecs[i].exp_wren);
      check("tbl_waddr", smp_waddr, vecs[i].exp_waddr);
      check("tbl_usedw", usedw, vecs[i].exp_usedw);
      check("tbl_empty", empty, vecs[i].exp_empty);
    end
`endif

    // fill to capacity, then overflow attempt
    cycle(0, 8'h00, 0, 1);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1, 8'(i + 8'h60), 0, 0);
      check("fill_af", almost_full, (i + 1) >= AFV);
      check("fill_full", full, (i + 1) == DEPTH);
    end
    cycle(1, 8'hAA, 0, 0);
    check("ovf_wren", smp_wren, 0);
    check("ovf_usedw", usedw, DEPTH);
    cycle(1, 8'hBB, 1, 0);
    check("full_rw_wren", smp_wren, 0);
    check("full_rw_usedw", usedw, DEPTH - 1);
    check("full_rw_full", full, 0);
    for (int i = 0; i < DEPTH + 4; i++) cycle(0, 8'h00, 1, 0);
    check("drain_usedw", usedw, 0);
    check("drain_empty", empty, 1);

    // sclr while a read is in flight
    cycle(0, 8'h00, 0, 1);
    for (int i = 0; i < 6; i++) cycle(1, 8'(i + 8'hC0), 0, 0);
    cycle(0, 8'h00, 0, 0);
    cycle(0, 8'h00, 1, 0);
    check("pre_sclr_usedw", usedw, 5);
    cycle(0, 8'h00, 0, 1);
    check("sclr_usedw", usedw, 0);
    check("sclr_empty", empty, 1);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 8'h00, 0, 0);
      check("sclr_stay_empty", empty, 1);
    end

    // pointer wrap with interleaved reads
    for (int i = 0; i < 20; i++) cycle(1, 8'(i * 7 + 3), i >= 4, 0);
    for (int i = 0; i < DEPTH + 4; i++) cycle(0, 8'h00, 1, 0);
    check("wrap_count", wr_cnt, 20);
    check("wrap_usedw", usedw, 0);

`ifdef RAM_FIFO_SHOWAHEAD_EN
    // first-word-fall-through latency and back-to-back drain
    cycle(0, 8'h00, 0, 1);
    cycle(1, 8'h5A, 0, 0);
    check("sa_lat0", empty, 1);
    cycle(0, 8'h00, 0, 0);
    check("sa_lat1", empty, 1);
    cycle(0, 8'h00, 0, 0);
    check("sa_lat2", empty, 0);
    check("sa_q5a", q, 8'h5A);
    for (int i = 0; i < 6; i++) cycle(1, 8'(i + 8'h90), 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 0, 0);
    for (int i = 0; i < 7; i++) begin
      check("sa_drain_ne", empty, 0);
      cycle(0, 8'h00, 1, 0);
    end
    check("sa_drain_empty", empty, 1);
    check("sa_drain_usedw", usedw, 0);
`endif

    // randomized traffic with alternating fill/drain bias
    for (int i = 0; i < 600; i++) begin
      int wp;
      wp = ((i / 100) % 2) ? 30 : 70;
      cycle($urandom_range(0, 99) < wp, 8'($urandom_range(0, 255)),
            $urandom_range(0, 99) < (100 - wp), $urandom_range(0, 127) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
